// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between a high-priority ALU path and a
// starvation-bounded multi-cycle path. Optional forwarding ports under WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [4:0]        s0_rd,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [4:0]        s1_rd,
  input  logic [DATA_W-1:0] s1_data,
  output logic              wb_write_enable,
  output logic [4:0]        wb_write_register,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              s1_starved
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]        byp_rs1,
  input  logic [4:0]        byp_rs2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        wait_cnt_p0;
  logic              grant0_p0;
  logic              grant1_p0;
  logic              vld_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] data_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Stage p0: grant decision from valids and the wait counter
  assign s1_starved = (wait_cnt_p0 >= LIMIT);

  always_comb begin
    grant0_p0 = !rst && s0_valid && (!s1_valid || !s1_starved);
    grant1_p0 = !rst && s1_valid && (!s0_valid || s1_starved);
  end

  assign s0_ready = grant0_p0;
  assign s1_ready = grant1_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_p0 <= 4'd0;
    end else if (s1_valid && !grant1_p0) begin
      wait_cnt_p0 <= sat_inc(wait_cnt_p0);
    end else begin
      wait_cnt_p0 <= 4'd0;
    end
  end

  // Stage p1: registered write port; rd==0 slots are consumed but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      rd_p1   <= 5'd0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= (grant0_p0 && (s0_rd != 5'd0)) || (grant1_p0 && (s1_rd != 5'd0));
      if (grant1_p0) begin
        rd_p1   <= s1_rd;
        data_p1 <= s1_data;
      end else if (grant0_p0) begin
        rd_p1   <= s0_rd;
        data_p1 <= s0_data;
      end
    end
  end

  assign wb_write_enable   = vld_p1;
  assign wb_write_register = rd_p1;
  assign wb_write_data     = data_p1;

`ifdef WB_BYPASS_EN
  assign byp_hit1  = vld_p1 && (rd_p1 == byp_rs1) && (byp_rs1 != 5'd0);
  assign byp_hit2  = vld_p1 && (rd_p1 == byp_rs2) && (byp_rs2 != 5'd0);
  assign byp_data1 = byp_hit1 ? data_p1 : '0;
  assign byp_data2 = byp_hit2 ? data_p1 : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a cycle-level
// behavioural model of the grant, starvation and writeback rules.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_rd, s1_rd;
  logic [31:0] s0_data, s1_data;
  logic        wb_write_enable;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;
  logic        s1_starved;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_rs1 = 5'd0, byp_rs2 = 5'd0;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  regfile_wb_arbiter #(.DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
    .wb_write_enable(wb_write_enable), .wb_write_register(wb_write_register),
    .wb_write_data(wb_write_data), .s1_starved(s1_starved)
`ifdef WB_BYPASS_EN
    , .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: cycles source 1 has waited, and the value on the write port.
  int          m_wait = 0;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        acc0, acc1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check combinational and registered outputs, advance one edge.
  task automatic cycle(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                       input logic r);
    int winner;
    logic starving;
    s0_valid = v0; s0_rd = r0; s0_data = d0;
    s1_valid = v1; s1_rd = r1; s1_data = d1;
    rst = r;
    #1;
    starving = (m_wait >= LIMIT);
    winner = -1;
    if (!r) begin
      if (v0 && v1)  winner = starving ? 1 : 0;
      else if (v0)   winner = 0;
      else if (v1)   winner = 1;
    end
    chk("s0_ready", s0_ready, winner == 0);
    chk("s1_ready", s1_ready, winner == 1);
    chk("s1_starved", s1_starved, starving);
    chk("wb_we", wb_write_enable, m_we);
    chk("wb_reg", wb_write_register, m_rd);
    chk("wb_data", wb_write_data, m_data);
`ifdef WB_BYPASS_EN
    chk("byp_hit1", byp_hit1, m_we && m_rd == byp_rs1 && byp_rs1 != 0);
    chk("byp_hit2", byp_hit2, m_we && m_rd == byp_rs2 && byp_rs2 != 0);
    chk("byp_data1", byp_data1, (m_we && m_rd == byp_rs1 && byp_rs1 != 0) ? m_data : 32'd0);
    chk("byp_data2", byp_data2, (m_we && m_rd == byp_rs2 && byp_rs2 != 0) ? m_data : 32'd0);
`endif
    if (r) begin
      m_wait = 0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0;
    end else begin
      if (v1 && winner != 1) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
      else                   m_wait = 0;
      m_we = 1'b0;
      if (winner == 0) begin m_rd = r0; m_data = d0; m_we = (r0 != 0); end
      if (winner == 1) begin m_rd = r1; m_data = d1; m_we = (r1 != 0); end
    end
    acc0 = (winner == 0);
    acc1 = (winner == 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r);
  endtask

  logic        p0, p1;
  logic [4:0]  pr0, pr1;
  logic [31:0] pd0, pd1;

  initial begin
    rst = 1'b1;
    s0_valid = 1'b0; s0_rd = 5'd0; s0_data = 32'd0;
    s1_valid = 1'b0; s1_rd = 5'd0; s1_data = 32'd0;
    @(posedge clk);
    #1;
    m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_wait = 0;

    // Reset then idle
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Single source 0 write
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("single_we", wb_write_enable, 1'b1);
    chk("single_reg", wb_write_register, 5'd5);
    chk("single_data", wb_write_data, 32'hDEADBEEF);
    idle(1'b0);

    // Starvation: s0 wins four cycles, s1 forced on the fifth
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'd7, 32'h11, 1'b0);
    chk("starve_reg", wb_write_register, 5'd7);
    chk("starve_data", wb_write_data, 32'h11);
    chk("starve_clear", s1_starved, 1'b0);
    cycle(1'b1, 5'd6, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0);

    // x0 discard
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0);
    chk("x0_we", wb_write_enable, 1'b0);
    idle(1'b0);

    // Reset mid-flight with requests still pending
    cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88, 1'b1);
    chk("midrst_we", wb_write_enable, 1'b0);
    chk("midrst_starved", s1_starved, 1'b0);
    idle(1'b0);

`ifdef WB_BYPASS_EN
    // Bypass of an in-flight write
    cycle(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
    byp_rs1 = 5'd9; byp_rs2 = 5'd0;
    #1;
    chk("byp_dir_hit1", byp_hit1, 1'b1);
    chk("byp_dir_data1", byp_data1, 32'hA5A5A5A5);
    chk("byp_dir_hit2", byp_hit2, 1'b0);
    idle(1'b0);
`endif

    // Randomized traffic; sources hold requests until accepted
    p0 = 1'b0; p1 = 1'b0;
    pr0 = 5'd0; pr1 = 5'd0; pd0 = 32'd0; pd1 = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; pr0 = 5'($urandom_range(0, 31)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; pr1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pd1 = $urandom;
      end
      r = ($urandom_range(0, 60) == 0);
`ifdef WB_BYPASS_EN
      byp_rs1 = $urandom_range(0, 1) ? m_rd : 5'($urandom_range(0, 31));
      byp_rs2 = $urandom_range(0, 1) ? m_rd : 5'($urandom_range(0, 31));
`endif
      cycle(p0, pr0, pd0, p1, pr1, pd1, r);
      if (acc0) p0 = 1'b0;
      if (acc1) p1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
